// File: rtl/task_dispatch_controller.sv
// task_dispatch_controller: sequences a pre-computed task-to-core schedule.
// Latches the assignment map, per-task cycle counts and frequency levels on
// start, validates the map, then runs each core's tasks back-to-back in
// ascending task index while counting the makespan.

// Per-core engine: picks the lowest-index pending task owned by this core and
// counts down its occupancy, reloading on the final cycle so there is no bubble.
module tdc_lane #(
    parameter int NUM_TASKS  = 10,
    parameter int DATA_WIDTH = 32,
    parameter int LVL_WIDTH  = 3
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            run,
    input  logic [NUM_TASKS-1:0]            assigned,
    input  logic [NUM_TASKS-1:0]            pending,
    input  logic [DATA_WIDTH*NUM_TASKS-1:0] exec_cycles,
    input  logic [LVL_WIDTH*NUM_TASKS-1:0]  freq_level,
    output logic [NUM_TASKS-1:0]            take,
    output logic                            free,
    output logic                            core_busy,
    output logic [3:0]                      core_task,
    output logic [LVL_WIDTH-1:0]            core_freq
);
    logic [DATA_WIDTH-1:0] cnt;
    logic [DATA_WIDTH-1:0] exec_sel;
    logic [LVL_WIDTH-1:0]  freq_sel;
    logic [NUM_TASKS-1:0]  cand;
    logic [3:0]            sel;
    logic                  has_next;

    assign cand     = assigned & pending;
    assign has_next = |cand;
    // Core can accept a new task this edge: idle, or in its last busy cycle.
    assign free     = !core_busy || (cnt == DATA_WIDTH'(1));

    // Lowest-index candidate; the one-hot claim goes back to the pending mask.
    always_comb begin
        sel = '0;
        for (int t = NUM_TASKS - 1; t >= 0; t--)
            if (cand[t]) sel = 4'(t);
        exec_sel = exec_cycles[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
        freq_sel = freq_level[int'(sel)*LVL_WIDTH +: LVL_WIDTH];
        take     = (run && free) ? (cand & (~cand + 1'b1)) : '0;
    end

    // Occupancy counter; zero-length tasks still hold the core for one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            core_busy <= 1'b0;
            core_task <= '0;
            core_freq <= '0;
        end else if (run) begin
            if (free) begin
                if (has_next) begin
                    core_busy <= 1'b1;
                    core_task <= sel;
                    core_freq <= freq_sel;
                    cnt       <= (exec_sel == '0) ? DATA_WIDTH'(1) : exec_sel;
                end else begin
                    core_busy <= 1'b0;
                    cnt       <= '0;
                end
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end
endmodule

module task_dispatch_controller #(
    parameter int NUM_TASKS      = 10,
    parameter int NUM_PROCESSORS = 3,
    parameter int DATA_WIDTH     = 32,
    parameter int LVL_WIDTH      = 3
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
    input  logic [NUM_PROCESSORS*NUM_TASKS-1:0] processor_assignment,
    input  logic [DATA_WIDTH*NUM_TASKS-1:0]     exec_cycles,
    input  logic [LVL_WIDTH*NUM_TASKS-1:0]      freq_level,
    output logic                                busy,
    output logic [NUM_PROCESSORS-1:0]           core_busy,
    output logic [4*NUM_PROCESSORS-1:0]         core_task,
    output logic [LVL_WIDTH*NUM_PROCESSORS-1:0] core_freq,
    output logic                                done,
    output logic                                error,
    output logic [DATA_WIDTH-1:0]               makespan
);
    typedef enum logic [1:0] {IDLE, CHECK, RUN, FINISH} state_t;

    state_t state, state_nxt;

    logic [NUM_PROCESSORS*NUM_TASKS-1:0]            asg_q;
    logic [DATA_WIDTH*NUM_TASKS-1:0]                exec_q;
    logic [LVL_WIDTH*NUM_TASKS-1:0]                 freq_q;
    logic [NUM_TASKS-1:0]                           pending;
    logic [NUM_TASKS-1:0][NUM_PROCESSORS-1:0]       task_col;
    logic [NUM_TASKS-1:0]                           task_ok;
    logic [NUM_PROCESSORS-1:0][NUM_TASKS-1:0]       take;
    logic [NUM_TASKS-1:0]                           take_all;
    logic [NUM_PROCESSORS-1:0]                      free;
    logic                                           map_bad;
    logic                                           run;

    assign run = (state == RUN);

    // A task is valid only when exactly one core claims it.
    for (genvar t = 0; t < NUM_TASKS; t++) begin : g_col
        for (genvar p = 0; p < NUM_PROCESSORS; p++) begin : g_bit
            assign task_col[t][p] = asg_q[p*NUM_TASKS + t];
        end
        assign task_ok[t] = (task_col[t] != '0) &&
                            ((task_col[t] & (task_col[t] - 1'b1)) == '0);
    end
    assign map_bad = ~&task_ok;

    for (genvar p = 0; p < NUM_PROCESSORS; p++) begin : g_lane
        tdc_lane #(
            .NUM_TASKS (NUM_TASKS),
            .DATA_WIDTH(DATA_WIDTH),
            .LVL_WIDTH (LVL_WIDTH)
        ) u_lane (
            .clk        (clk),
            .reset      (reset),
            .run        (run),
            .assigned   (asg_q[p*NUM_TASKS +: NUM_TASKS]),
            .pending    (pending),
            .exec_cycles(exec_q),
            .freq_level (freq_q),
            .take       (take[p]),
            .free       (free[p]),
            .core_busy  (core_busy[p]),
            .core_task  (core_task[p*4 +: 4]),
            .core_freq  (core_freq[p*LVL_WIDTH +: LVL_WIDTH])
        );
    end

    // Tasks claimed by any core this edge leave the pending mask.
    always_comb begin
        take_all = '0;
        for (int p = 0; p < NUM_PROCESSORS; p++) take_all |= take[p];
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state: run ends once nothing is pending and every core is on its
    // last cycle or already idle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CHECK;
            CHECK:   state_nxt = map_bad ? FINISH : RUN;
            RUN:     if (pending == '0 && &free) state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Status outputs decoded from state.
    always_comb begin
        busy = (state != IDLE);
        done = (state == FINISH);
    end

    // Input latch, pending mask, error flag and saturating makespan counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            asg_q    <= '0;
            exec_q   <= '0;
            freq_q   <= '0;
            pending  <= '0;
            error    <= 1'b0;
            makespan <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    asg_q    <= processor_assignment;
                    exec_q   <= exec_cycles;
                    freq_q   <= freq_level;
                    pending  <= '0;
                    error    <= 1'b0;
                    makespan <= '0;
                end
                CHECK: begin
                    if (map_bad) error   <= 1'b1;
                    else         pending <= '1;
                end
                RUN: begin
                    pending <= pending & ~take_all;
                    if (|core_busy && makespan != {DATA_WIDTH{1'b1}})
                        makespan <= makespan + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_task_dispatch_controller.sv
// Bench for task_dispatch_controller: directed scenarios plus randomized
// schedules, each checked cycle by cycle against a schedule-level model.
module tb_task_dispatch_controller;
    localparam int NT = 5;
    localparam int NP = 3;
    localparam int DW = 4;
    localparam int LW = 3;
    localparam int MS_MAX = (1 << DW) - 1;

    logic clk = 1'b0;
    logic reset, start;
    logic [NP*NT-1:0] processor_assignment;
    logic [DW*NT-1:0] exec_cycles;
    logic [LW*NT-1:0] freq_level;
    logic busy, done, error;
    logic [NP-1:0]    core_busy;
    logic [4*NP-1:0]  core_task;
    logic [LW*NP-1:0] core_freq;
    logic [DW-1:0]    makespan;

    int n_chk = 0;
    int n_err = 0;
    int prev_task[NP];
    int prev_freq[NP];
    logic [NP*NT-1:0] d_asg;
    logic [DW*NT-1:0] d_ex;
    logic [LW*NT-1:0] d_fq;

    task_dispatch_controller #(
        .NUM_TASKS(NT), .NUM_PROCESSORS(NP), .DATA_WIDTH(DW), .LVL_WIDTH(LW)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .processor_assignment(processor_assignment),
        .exec_cycles(exec_cycles), .freq_level(freq_level),
        .busy(busy), .core_busy(core_busy), .core_task(core_task),
        .core_freq(core_freq), .done(done), .error(error), .makespan(makespan)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_task(input int t, input int p, input int e, input int f);
        for (int q = 0; q < NP; q++) d_asg[q*NT + t] = (q == p);
        d_ex[t*DW +: DW] = DW'(e);
        d_fq[t*LW +: LW] = LW'(f);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_core_busy"}, int'(core_busy), 0);
        chk({tag, "_core_task"}, int'(core_task), 0);
        chk({tag, "_core_freq"}, int'(core_freq), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_error"}, int'(error), 0);
        chk({tag, "_makespan"}, int'(makespan), 0);
    endtask

    // Model: every core runs its own tasks in ascending index, each for
    // max(exec,1) cycles, starting together; start at edge 0, CHECK, one
    // RUN cycle to load, then busy cycles, then FINISH.
    task automatic run_case(input logic [NP*NT-1:0] asg, input logic [DW*NT-1:0] ex,
                            input logic [LW*NT-1:0] fq, input bit disturb, input int exp_ms);
        int dur[NT];
        int owner[NT];
        int total[NP];
        int cur_t[NP];
        int cur_f[NP];
        int bits, m, end_n, k, acc, dn, ms;
        bit bad;
        logic [NP-1:0]    e_cb;
        logic [4*NP-1:0]  e_ct;
        logic [LW*NP-1:0] e_cf;
        bad = 0;
        for (int t = 0; t < NT; t++) begin
            bits = 0;
            owner[t] = -1;
            for (int p = 0; p < NP; p++)
                if (asg[p*NT + t]) begin bits++; owner[t] = p; end
            if (bits != 1) bad = 1;
            dur[t] = (ex[t*DW +: DW] == 0) ? 1 : int'(ex[t*DW +: DW]);
        end
        m = 0;
        for (int p = 0; p < NP; p++) begin
            total[p] = 0;
            for (int t = 0; t < NT; t++) if (owner[t] == p) total[p] += dur[t];
            if (!bad && total[p] > m) m = total[p];
        end
        end_n = bad ? 2 : 3 + m;

        @(negedge clk);
        processor_assignment = asg;
        exec_cycles = ex;
        freq_level = fq;
        start = 1'b1;
        dn = 0;
        for (int n = 1; n <= end_n + 2; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
            k = n - 3;
            for (int p = 0; p < NP; p++) begin
                cur_t[p] = prev_task[p];
                cur_f[p] = prev_freq[p];
                e_cb[p] = 1'b0;
                if (!bad && n >= 3) begin
                    acc = 0;
                    for (int t = 0; t < NT; t++)
                        if (owner[t] == p) begin
                            if (acc <= k) begin
                                cur_t[p] = t;
                                cur_f[p] = int'(fq[t*LW +: LW]);
                            end
                            acc += dur[t];
                        end
                    e_cb[p] = (k < total[p]);
                end
                e_ct[p*4 +: 4] = 4'(cur_t[p]);
                e_cf[p*LW +: LW] = LW'(cur_f[p]);
            end
            ms = (bad || k <= 0) ? 0 : ((k < m) ? k : m);
            if (ms > MS_MAX) ms = MS_MAX;
            chk("busy", int'(busy), int'(n <= end_n));
            chk("done", int'(done), int'(n == end_n));
            chk("error", int'(error), int'(bad && n >= 2));
            chk("core_busy", int'(core_busy), int'(e_cb));
            chk("core_task", int'(core_task), int'(e_ct));
            chk("core_freq", int'(core_freq), int'(e_cf));
            chk("makespan", int'(makespan), ms);
            if (done) dn++;
            if (disturb && !bad && n == 3) begin
                start = 1'b1;
                processor_assignment = (NP*NT)'($urandom);
                exec_cycles = (DW*NT)'($urandom);
                freq_level = (LW*NT)'($urandom);
            end
            if (n == 4) start = 1'b0;
        end
        chk("done_count", dn, 1);
        if (exp_ms >= 0) chk("makespan_final", int'(makespan), exp_ms);
        for (int p = 0; p < NP; p++) begin
            prev_task[p] = cur_t[p];
            prev_freq[p] = cur_f[p];
        end
    endtask

    task automatic reset_mid_run();
        int dn;
        for (int t = 0; t < NT; t++) set_task(t, 0, 3, t + 1);
        @(negedge clk);
        processor_assignment = d_asg;
        exec_cycles = d_ex;
        freq_level = d_fq;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2 reset = 1'b1;
        #1 chk_all_zero("midrun_reset");
        @(negedge clk);
        reset = 1'b0;
        for (int p = 0; p < NP; p++) begin prev_task[p] = 0; prev_freq[p] = 0; end
        dn = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) dn++;
        end
        chk("no_done_after_reset", dn, 0);
        chk("idle_after_reset", int'(busy), 0);
    endtask

    initial begin
        logic [NP*NT-1:0] asg;
        logic [DW*NT-1:0] ex;
        logic [LW*NT-1:0] fq;
        int p, t;
        reset = 1'b1;
        start = 1'b0;
        processor_assignment = '0;
        exec_cycles = '0;
        freq_level = '0;
        d_asg = '0; d_ex = '0; d_fq = '0;
        for (int i = 0; i < NP; i++) begin prev_task[i] = 0; prev_freq[i] = 0; end
        #1 chk_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // three tasks back-to-back on core 0, levels 5/2/7
        set_task(0, 0, 2, 5); set_task(1, 0, 3, 2); set_task(2, 0, 1, 7);
        set_task(3, 1, 1, 1); set_task(4, 2, 1, 3);
        run_case(d_asg, d_ex, d_fq, 1'b0, 6);
        // split across cores, core 1 chains T1 then T2
        set_task(0, 0, 4, 1); set_task(1, 1, 2, 4); set_task(2, 1, 3, 6);
        set_task(3, 2, 1, 2); set_task(4, 0, 1, 0);
        run_case(d_asg, d_ex, d_fq, 1'b0, 5);
        // task 4 claimed by two cores
        d_asg[0*NT + 4] = 1'b1; d_asg[1*NT + 4] = 1'b1;
        run_case(d_asg, d_ex, d_fq, 1'b0, 0);
        // task with no core at all
        for (int q = 0; q < NP; q++) d_asg[q*NT + 2] = 1'b0;
        run_case(d_asg, d_ex, d_fq, 1'b0, 0);
        // zero-cycle tasks count as one cycle; T4 alone on core 2
        set_task(0, 0, 0, 1); set_task(1, 0, 0, 2); set_task(2, 1, 0, 3);
        set_task(3, 1, 0, 4); set_task(4, 2, 0, 5);
        run_case(d_asg, d_ex, d_fq, 1'b0, 2);
        // makespan saturates at all-ones
        set_task(0, 0, 7, 1); set_task(1, 0, 7, 2); set_task(2, 0, 7, 3);
        set_task(3, 1, 1, 4); set_task(4, 2, 1, 5);
        run_case(d_asg, d_ex, d_fq, 1'b0, MS_MAX);
        // start and input changes during RUN are ignored
        set_task(0, 0, 2, 5); set_task(1, 0, 3, 2); set_task(2, 0, 1, 7);
        set_task(3, 1, 1, 1); set_task(4, 2, 1, 3);
        run_case(d_asg, d_ex, d_fq, 1'b1, 6);

        reset_mid_run();
        set_task(0, 0, 4, 1); set_task(1, 1, 2, 4); set_task(2, 1, 3, 6);
        set_task(3, 2, 1, 2); set_task(4, 0, 1, 0);
        run_case(d_asg, d_ex, d_fq, 1'b0, 5);

        for (int i = 0; i < 40; i++) begin
            asg = '0;
            for (int j = 0; j < NT; j++) begin
                p = $urandom_range(NP - 1);
                asg[p*NT + j] = 1'b1;
                ex[j*DW +: DW] = DW'($urandom_range(0, 7));
                fq[j*LW +: LW] = LW'($urandom_range(0, 7));
            end
            if ($urandom_range(5) == 0) begin
                t = $urandom_range(NT - 1);
                for (int q = 0; q < NP; q++) asg[q*NT + t] = $urandom_range(1) == 1;
            end
            run_case(asg, ex, fq, $urandom_range(3) == 0, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got %0d checks expected completion", n_chk);
        $fatal(1, "timeout");
    end
endmodule
